// File: rtl/rq_stream_arbiter.sv
// rq_stream_arbiter: packet-level round-robin arbiter merging N_PORTS AXI-Stream TLP
// sources onto the single RQ path; the owner keeps the stream until its tlast is accepted.
module rq_stream_arbiter #(
  parameter int N_PORTS    = 2,
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 62
) (
  input  logic                           user_clk,
  input  logic                           user_reset_n,
  input  logic [N_PORTS-1:0]             s_axis_tvalid,
  output logic [N_PORTS-1:0]             s_axis_tready,
  input  logic [N_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [N_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [N_PORTS-1:0]             s_axis_tlast,
  input  logic [N_PORTS*USER_WIDTH-1:0]  s_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic [3:0]                     m_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic [USER_WIDTH-1:0]          m_axis_tuser,
  output logic [N_PORTS-1:0]             grant,
  output logic                           busy
);

  // state | meaning
  // IDLE  | no owner; round-robin pick starting at rr_ptr is registered this cycle
  // BUSY  | grant_r owns the stream until its tlast beat is accepted

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [N_PORTS-1:0] grant_r, grant_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   grant_idx;
  logic               pick_found;
  logic               last_xfer;
  logic               unused_tready;

  // Only bit 0 of the sink ready bus carries meaning.
  assign unused_tready = ^m_axis_tready[3:1];

  always_comb begin : rr_pick
    logic [N_PORTS-1:0] req_rot;
    logic [PTR_W:0]     sum;
    req_rot    = N_PORTS'({s_axis_tvalid, s_axis_tvalid} >> rr_ptr);
    pick_found = 1'b0;
    pick_idx   = '0;
    sum        = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!pick_found && req_rot[i]) begin
        pick_found = 1'b1;
        sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
        if (sum >= (PTR_W+1)'(N_PORTS)) sum = sum - (PTR_W+1)'(N_PORTS);
        pick_idx = sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_r[i]) grant_idx = PTR_W'(i);
    end
  end

  assign last_xfer = |(grant_r & s_axis_tvalid & s_axis_tlast) & m_axis_tready[0];

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state   <= IDLE;
      grant_r <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      grant_r <= grant_nxt;
      rr_ptr  <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_r;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = BUSY;
          grant_nxt = N_PORTS'(1) << pick_idx;
        end
      end
      BUSY: begin
        if (last_xfer) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          rr_ptr_nxt = (grant_idx == PTR_W'(N_PORTS-1)) ? '0 : grant_idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // grant_r is zero in IDLE, so every forwarded signal is naturally quiet there.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (grant_r[p]) begin
        m_axis_tvalid = s_axis_tvalid[p];
        m_axis_tdata  = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep  = s_axis_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_tlast  = s_axis_tlast[p];
        m_axis_tuser  = s_axis_tuser[p*USER_WIDTH +: USER_WIDTH];
      end
    end
    s_axis_tready = grant_r & {N_PORTS{m_axis_tready[0]}};
    grant         = grant_r;
    busy          = (state == BUSY);
  end

endmodule
